// File: rtl/pipe_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port plus the
// decode-facing instruction stream and redirect controls.
interface pipe_fetch_unit_if #(
  parameter int DW    = 32,
  parameter int AW    = 11,
  parameter int DEPTH = 4
);
  logic [AW-1:0]              i_addr;
  logic                       im_oen;
  logic [DW-1:0]              ir;
  logic                       stall;
  logic                       redirect;
  logic [AW-1:0]              redirect_pc;
  logic [DW-1:0]              inst;
  logic [AW-1:0]              inst_pc;
  logic                       inst_valid;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output i_addr, im_oen,
    output inst, inst_pc, inst_valid, count,
    input  ir, stall, redirect, redirect_pc
  );

  modport slave (
    input  i_addr, im_oen,
    input  inst, inst_pc, inst_valid, count,
    output ir, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage: credit-based issue to a fixed-latency
// memory, prefetch FIFO towards decode, flush on redirect.
module pipe_fetch_unit #(
  parameter int              DW       = 32,
  parameter int              AW       = 11,
  parameter int              DEPTH    = 4,
  parameter int              MEM_LAT  = 1,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [DW-1:0]   NOP      = '0
) (
  input logic               clk,
  input logic               rst_n,
  pipe_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + MEM_LAT + 1);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] pc;
  } slot_t;

  logic [AW-1:0]        fpc;
  logic [AW-1:0]        addr_q;
  logic                 oen_q;
  slot_t [MEM_LAT-1:0]  pipe;
  logic [DW-1:0]        fifo_d  [DEPTH];
  logic [AW-1:0]        fifo_pc [DEPTH];
  logic [PW-1:0]        rd;
  logic [PW-1:0]        wr;
  logic [CW-1:0]        cnt;
  logic [OW-1:0]        inflight;
  logic [OW-1:0]        occ;
  logic                 valid;
  logic                 push;
  logic                 pop;
  logic                 issue;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++)
      inflight = inflight + OW'(pipe[i].v);
  end

  assign valid = cnt != '0;
  assign pop   = valid && !bus.stall;
  assign push  = pipe[MEM_LAT-1].v;

  // A head leaving this edge frees its credit immediately,
  // which keeps DEPTH = MEM_LAT+1 bubble-free.
  assign occ   = OW'(cnt) + inflight - OW'(pop);
  assign issue = occ < OW'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      addr_q <= '0;
      oen_q  <= 1'b1;
      pipe   <= '0;
      rd     <= '0;
      wr     <= '0;
      cnt    <= '0;
    end else if (bus.redirect) begin
      fpc    <= bus.redirect_pc;
      oen_q  <= 1'b1;
      pipe   <= '0;
      rd     <= '0;
      wr     <= '0;
      cnt    <= '0;
    end else begin
      if (issue) begin
        addr_q <= fpc;
        oen_q  <= 1'b0;
        fpc    <= fpc + 1'b1;
      end else begin
        oen_q  <= 1'b1;
      end
      pipe[0] <= '{v: issue, pc: fpc};
      for (int i = 1; i < MEM_LAT; i++)
        pipe[i] <= pipe[i-1];
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.redirect && push) begin
      fifo_d[wr]  <= bus.ir;
      fifo_pc[wr] <= pipe[MEM_LAT-1].pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.redirect && push && !pop)
      assert (cnt < CW'(DEPTH));
  end

  assign bus.i_addr     = addr_q;
  assign bus.im_oen     = oen_q;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? fifo_d[rd] : NOP;
  assign bus.inst_pc    = valid ? fifo_pc[rd] : '0;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: 3-edge memory model and a
// request-queue reference model of the fetch stream.
module tb_pipe_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 4;
  localparam int MEM_LAT = 3;
  localparam logic [AW-1:0] RESET_PC = 4'd14;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nerr = 0;

  pipe_fetch_unit_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

  pipe_fetch_unit #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT),
    .RESET_PC(RESET_PC), .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {28'hC0DE000, a};
  endfunction

  // Memory: address registered at edge k, data sampled at edge k+3.
  logic [AW-1:0] da1, da2;
  logic do1 = 1'b1, do2 = 1'b1;
  logic [DW-1:0] junk;
  always @(posedge clk) begin
    da1 <= bus.i_addr;
    do1 <= bus.im_oen;
    da2 <= da1;
    do2 <= do1;
    junk <= {4'hB, 28'($urandom)};
  end
  assign bus.ir = do2 ? junk : mem_word(da2);

  // Reference: every request not yet consumed, with the edge
  // at which its word lands in the prefetch buffer.
  typedef struct {
    logic [AW-1:0] pc;
    int rdy;
  } req_t;
  req_t q[$];
  logic [AW-1:0] m_fpc = RESET_PC;
  logic [AW-1:0] m_addr = '0;
  logic m_oen = 1'b1;
  int e = -1;

  function automatic logic m_valid();
    return q.size() > 0 && q[0].rdy <= e;
  endfunction
  function automatic logic [AW-1:0] m_pc();
    return m_valid() ? q[0].pc : '0;
  endfunction
  function automatic logic [DW-1:0] m_inst();
    return m_valid() ? mem_word(q[0].pc) : NOP;
  endfunction
  function automatic int m_count();
    int n = 0;
    foreach (q[i]) if (q[i].rdy <= e) n++;
    return n;
  endfunction

  task automatic step(input logic s, input logic r,
                      input logic [AW-1:0] rp, input logic rn);
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = rp;
    rst_n = rn;
    @(posedge clk);
    e++;
    if (!rn) begin
      q.delete();
      m_fpc = RESET_PC;
      m_addr = '0;
      m_oen = 1'b1;
    end else if (r) begin
      q.delete();
      m_fpc = rp;
      m_oen = 1'b1;
    end else begin
      if (q.size() > 0 && q[0].rdy < e && !s) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{pc: m_fpc, rdy: e + MEM_LAT});
        m_addr = m_fpc;
        m_oen = 1'b0;
        m_fpc = m_fpc + 1'b1;
      end else begin
        m_oen = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    nchk++; if (bus.im_oen !== 1'b1) begin nerr++; $display("FAIL reset_oen: got %b want 1", bus.im_oen); end
    nchk++; if (bus.i_addr !== '0) begin nerr++; $display("FAIL reset_addr: got %h want 0", bus.i_addr); end
    nchk++; if (bus.inst_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
    nchk++; if (bus.inst !== NOP) begin nerr++; $display("FAIL reset_inst: got %h want %h", bus.inst, NOP); end
    nchk++; if (bus.inst_pc !== '0) begin nerr++; $display("FAIL reset_pc: got %h want 0", bus.inst_pc); end
    nchk++; if (bus.count !== '0) begin nerr++; $display("FAIL reset_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] p;
    step(1'b0, 1'b0, '0, 1'b1);
    nchk++; if (bus.i_addr !== RESET_PC) begin nerr++; $display("FAIL first_addr: got %h want %h", bus.i_addr, RESET_PC); end
    nchk++; if (bus.im_oen !== 1'b0) begin nerr++; $display("FAIL first_oen: got %b want 0", bus.im_oen); end
    for (int k = 1; k <= MEM_LAT; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      nchk++; if (bus.inst_valid !== (k == MEM_LAT)) begin nerr++; $display("FAIL latency_valid@%0d: got %b want %b", k, bus.inst_valid, k == MEM_LAT); end
    end
    nchk++; if (bus.inst_pc !== RESET_PC) begin nerr++; $display("FAIL first_pc: got %h want %h", bus.inst_pc, RESET_PC); end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      p = RESET_PC + AW'(k);
      nchk++; if (bus.inst_pc !== p) begin nerr++; $display("FAIL stream_pc@%0d: got %h want %h", k, bus.inst_pc, p); end
      nchk++; if (bus.inst !== mem_word(p)) begin nerr++; $display("FAIL stream_inst@%0d: got %h want %h", k, bus.inst, mem_word(p)); end
      nchk++; if (bus.count !== 3'd1) begin nerr++; $display("FAIL stream_count@%0d: got %0d want 1", k, bus.count); end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      nchk++; if (bus.count !== 3'(m_count())) begin nerr++; $display("FAIL stall_count@%0d: got %0d want %0d", k, bus.count, m_count()); end
      nchk++; if (bus.inst_pc !== m_pc()) begin nerr++; $display("FAIL stall_head@%0d: got %h want %h", k, bus.inst_pc, m_pc()); end
    end
    nchk++; if (bus.count !== 3'(DEPTH)) begin nerr++; $display("FAIL stall_full: got %0d want %0d", bus.count, DEPTH); end
    nchk++; if (bus.im_oen !== 1'b1) begin nerr++; $display("FAIL stall_oen: got %b want 1", bus.im_oen); end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      nchk++; if (bus.inst_pc !== m_pc()) begin nerr++; $display("FAIL drain_pc@%0d: got %h want %h", k, bus.inst_pc, m_pc()); end
      nchk++; if (bus.inst !== m_inst()) begin nerr++; $display("FAIL drain_inst@%0d: got %h want %h", k, bus.inst, m_inst()); end
      nchk++; if (bus.count !== 3'(m_count())) begin nerr++; $display("FAIL drain_count@%0d: got %0d want %0d", k, bus.count, m_count()); end
      nchk++; if (bus.im_oen !== m_oen) begin nerr++; $display("FAIL drain_oen@%0d: got %b want %b", k, bus.im_oen, m_oen); end
    end
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    nchk++; if (bus.count !== 3'd3) begin nerr++; $display("FAIL pre_redirect_count: got %0d want 3", bus.count); end
    step(1'b0, 1'b1, 4'd5, 1'b1);
    nchk++; if (bus.inst_valid !== 1'b0) begin nerr++; $display("FAIL redir_valid: got %b want 0", bus.inst_valid); end
    nchk++; if (bus.inst !== NOP) begin nerr++; $display("FAIL redir_inst: got %h want %h", bus.inst, NOP); end
    nchk++; if (bus.count !== '0) begin nerr++; $display("FAIL redir_count: got %0d want 0", bus.count); end
    nchk++; if (bus.im_oen !== 1'b1) begin nerr++; $display("FAIL redir_oen: got %b want 1", bus.im_oen); end
    for (int k = 1; k <= 1 + MEM_LAT; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (k == 1) begin
        nchk++; if (bus.i_addr !== 4'd5) begin nerr++; $display("FAIL redir_addr: got %h want 5", bus.i_addr); end
      end
      nchk++; if (bus.inst_valid !== (k == 1 + MEM_LAT)) begin nerr++; $display("FAIL redir_lat@%0d: got %b want %b", k, bus.inst_valid, k == 1 + MEM_LAT); end
    end
    nchk++; if (bus.inst !== mem_word(4'd5)) begin nerr++; $display("FAIL redir_first: got %h want %h", bus.inst, mem_word(4'd5)); end
    step(1'b0, 1'b0, '0, 1'b1);
    nchk++; if (bus.inst_pc !== 4'd6) begin nerr++; $display("FAIL redir_second: got %h want 6", bus.inst_pc); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] p;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 4'd2, 1'b1);
    step(1'b0, 1'b1, 4'd9, 1'b1);
    nchk++; if (bus.im_oen !== 1'b1) begin nerr++; $display("FAIL b2b_oen: got %b want 1", bus.im_oen); end
    for (int k = 1; k <= 1 + MEM_LAT; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      nchk++; if (bus.inst_valid !== (k == 1 + MEM_LAT)) begin nerr++; $display("FAIL b2b_lat@%0d: got %b want %b", k, bus.inst_valid, k == 1 + MEM_LAT); end
    end
    for (int k = 0; k < 6; k++) begin
      p = 4'd9 + AW'(k);
      nchk++; if (bus.inst_pc !== p) begin nerr++; $display("FAIL b2b_pc@%0d: got %h want %h", k, bus.inst_pc, p); end
      nchk++; if (bus.inst !== mem_word(p)) begin nerr++; $display("FAIL b2b_inst@%0d: got %h want %h", k, bus.inst, mem_word(p)); end
      step(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    nchk++; if (bus.im_oen !== 1'b1) begin nerr++; $display("FAIL mid_oen: got %b want 1", bus.im_oen); end
    nchk++; if (bus.i_addr !== '0) begin nerr++; $display("FAIL mid_addr: got %h want 0", bus.i_addr); end
    nchk++; if (bus.inst_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid: got %b want 0", bus.inst_valid); end
    nchk++; if (bus.inst !== NOP) begin nerr++; $display("FAIL mid_inst: got %h want %h", bus.inst, NOP); end
    nchk++; if (bus.count !== '0) begin nerr++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    step(1'b0, 1'b0, '0, 1'b1);
    nchk++; if (bus.i_addr !== RESET_PC) begin nerr++; $display("FAIL mid_restart: got %h want %h", bus.i_addr, RESET_PC); end
    for (int k = 1; k <= MEM_LAT; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      nchk++; if (bus.inst_valid !== (k == MEM_LAT)) begin nerr++; $display("FAIL mid_lat@%0d: got %b want %b", k, bus.inst_valid, k == MEM_LAT); end
    end
    nchk++; if (bus.inst_pc !== RESET_PC) begin nerr++; $display("FAIL mid_first: got %h want %h", bus.inst_pc, RESET_PC); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic s, r, rn;
      logic [AW-1:0] rp;
      s  = $urandom_range(0, 9) < 4;
      r  = $urandom_range(0, 19) == 0;
      rn = $urandom_range(0, 99) != 0;
      rp = AW'($urandom);
      step(s, r, rp, rn);
      nchk++; if (bus.inst_valid !== m_valid()) begin nerr++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.inst_valid, m_valid()); end
      nchk++; if (bus.inst !== m_inst()) begin nerr++; $display("FAIL rnd_inst@%0d: got %h want %h", n, bus.inst, m_inst()); end
      nchk++; if (bus.inst_pc !== m_pc()) begin nerr++; $display("FAIL rnd_pc@%0d: got %h want %h", n, bus.inst_pc, m_pc()); end
      nchk++; if (bus.count !== 3'(m_count())) begin nerr++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, bus.count, m_count()); end
      nchk++; if (bus.im_oen !== m_oen) begin nerr++; $display("FAIL rnd_oen@%0d: got %b want %b", n, bus.im_oen, m_oen); end
      nchk++; if (!m_oen && bus.i_addr !== m_addr) begin nerr++; $display("FAIL rnd_addr@%0d: got %h want %h", n, bus.i_addr, m_addr); end
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
